// File: rtl/gelu_lane_dispatcher.sv
// Serial-to-lane packer for the GELU lane array: clamps Q48.16 activations to
// the GELU working range and groups LANES consecutive elements into one masked vector.
module gelu_lane_dispatcher #(
    parameter int                     W         = 64,
    parameter int                     Q         = 16,
    parameter int                     LANES     = 8,
    parameter logic signed [W-1:0]    CLAMP_MAX = 64'sh0000_0000_0008_0000,
    parameter int                     CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [W-1:0]         s_data,
    input  logic                 s_last,
    output logic                 v_valid,
    input  logic                 v_ready,
    output logic [LANES*W-1:0]   v_data,
    output logic [LANES-1:0]     v_mask,
    output logic                 v_last,
    input  logic                 sat_clr,
    output logic [CNT_W-1:0]     sat_count,
    output logic                 dbg_state_o
);

    localparam int IDX_W = $clog2(LANES);
    localparam logic signed [W-1:0] NEG_CLAMP = -CLAMP_MAX;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    generate
        if (Q >= W || LANES < 2 || LANES > 32 || (LANES & (LANES - 1)) != 0) begin : g_param_check
            $error("gelu_lane_dispatcher: unsupported parameter combination");
        end
    endgenerate

    // Valid/ready: a transfer happens on a rising edge where valid and ready
    // are both high. s_ready depends only on state, never on s_valid;
    // v_valid is held with stable v_data/v_mask/v_last until v_ready is seen.

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [LANES*W-1:0]    lanes_q, lanes_d;
    logic [LANES-1:0]      mask_q, mask_d;
    logic                  last_q, last_d;
    logic [CNT_W-1:0]      sat_q, sat_d;

    logic                  accept;
    logic                  v_fire;
    logic                  vec_done;
    logic signed [W-1:0]   x_in;
    logic signed [W-1:0]   x_clamped;
    logic                  x_was_clamped;

    // Boundary values +/-CLAMP_MAX are inside the working range and pass through.
    always_comb begin
        x_in          = $signed(s_data);
        x_clamped     = x_in;
        x_was_clamped = 1'b0;
        if (x_in > CLAMP_MAX) begin
            x_clamped     = CLAMP_MAX;
            x_was_clamped = 1'b1;
        end else if (x_in < NEG_CLAMP) begin
            x_clamped     = NEG_CLAMP;
            x_was_clamped = 1'b1;
        end
    end

    assign accept   = s_valid & s_ready;
    assign v_fire   = v_valid & v_ready;
    assign vec_done = accept & ((idx_q == LAST_IDX) | s_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (vec_done) state_d = HOLD;
            HOLD:    if (v_ready)  state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        v_valid = 1'b0;
        case (state_q)
            FILL:    s_ready = 1'b1;
            HOLD:    v_valid = 1'b1;
            default: s_ready = 1'b0;
        endcase
    end

    // Lane buffer is wiped on handover so a following partial vector shows zeros in unused lanes.
    always_comb begin
        idx_d   = idx_q;
        lanes_d = lanes_q;
        mask_d  = mask_q;
        last_d  = last_q;
        if (v_fire) begin
            lanes_d = '0;
            mask_d  = '0;
            last_d  = 1'b0;
        end else if (accept) begin
            lanes_d[idx_q*W +: W] = x_clamped;
            mask_d[idx_q]         = 1'b1;
            if (vec_done) begin
                idx_d  = '0;
                last_d = s_last;
            end else begin
                idx_d  = idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        sat_d = sat_q;
        if (sat_clr) begin
            sat_d = '0;
        end else if (accept && x_was_clamped && (sat_q != '1)) begin
            sat_d = sat_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            lanes_q <= '0;
            mask_q  <= '0;
            last_q  <= 1'b0;
            sat_q   <= '0;
        end else begin
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
            mask_q  <= mask_d;
            last_q  <= last_d;
            sat_q   <= sat_d;
        end
    end

    assign v_data      = lanes_q;
    assign v_mask      = mask_q;
    assign v_last      = last_q;
    assign sat_count   = sat_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gelu_lane_dispatcher.sv
// Bench for gelu_lane_dispatcher: directed steps plus random traffic, checked
// against a queue-based model of clamp, packing and saturation counting.
module tb_gelu_lane_dispatcher;

    localparam int W       = 64;
    localparam int LANES   = 8;
    localparam int CNT_W   = 16;
    localparam int VW      = LANES * W;
    localparam longint CLAMP = 64'h0000_0000_0008_0000;
    localparam int SAT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [W-1:0]      s_data;
    logic              s_last;
    logic              v_valid;
    logic              v_ready;
    logic [VW-1:0]     v_data;
    logic [LANES-1:0]  v_mask;
    logic              v_last;
    logic              sat_clr;
    logic [CNT_W-1:0]  sat_count;
    logic              dbg_state_o;

    gelu_lane_dispatcher dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .v_valid     (v_valid),
        .v_ready     (v_ready),
        .v_data      (v_data),
        .v_mask      (v_mask),
        .v_last      (v_last),
        .sat_clr     (sat_clr),
        .sat_count   (sat_count),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: elements collected so far, vectors awaiting handover, counter.
    longint           cur[$];
    logic [VW-1:0]    exp_q[$];
    logic [LANES-1:0] exp_mask_q[$];
    logic             exp_last_q[$];
    bit               m_hold = 0;
    int               m_sat  = 0;

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint ref_clamp(input longint x);
        if (x > CLAMP) return CLAMP;
        if (x < -CLAMP) return -CLAMP;
        return x;
    endfunction

    function automatic logic [W-1:0] rand_elem();
        longint v;
        case ($urandom_range(0, 5))
            0: v = longint'($urandom_range(0, 16 << 16)) - (8 << 16);
            1: v = CLAMP;
            2: v = -CLAMP;
            3: v = CLAMP + 1;
            4: v = -CLAMP - 1;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic model_reset();
        cur.delete();
        exp_q.delete();
        exp_mask_q.delete();
        exp_last_q.delete();
        m_hold = 0;
        m_sat  = 0;
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input logic sv, input logic [W-1:0] sd, input logic sl,
                         input logic vr, input logic clr, output bit acc, output bit fire);
        logic [VW-1:0]    d;
        logic [LANES-1:0] m;
        s_valid = sv;
        s_data  = sd;
        s_last  = sl;
        v_ready = vr;
        sat_clr = clr;
        check("s_ready", VW'(s_ready), VW'(!m_hold));
        check("v_valid", VW'(v_valid), VW'(m_hold));
        check("dbg_state", VW'(dbg_state_o), VW'(m_hold));
        check("sat_count", VW'(sat_count), VW'(m_sat));
        if (m_hold) begin
            check("v_data", v_data, exp_q[0]);
            check("v_mask", VW'(v_mask), VW'(exp_mask_q[0]));
            check("v_last", VW'(v_last), VW'(exp_last_q[0]));
        end
        acc  = !m_hold && sv;
        fire = m_hold && vr;
        if (fire) begin
            void'(exp_q.pop_front());
            void'(exp_mask_q.pop_front());
            void'(exp_last_q.pop_front());
            m_hold = 0;
        end else if (acc) begin
            cur.push_back(ref_clamp(longint'(sd)));
            if (sl || cur.size() == LANES) begin
                d = '0;
                m = '0;
                foreach (cur[i]) begin
                    d[i*W +: W] = cur[i];
                    m[i] = 1'b1;
                end
                exp_q.push_back(d);
                exp_mask_q.push_back(m);
                exp_last_q.push_back(sl);
                cur.delete();
                m_hold = 1;
            end
        end
        if (clr) m_sat = 0;
        else if (acc && ref_clamp(longint'(sd)) != longint'(sd)) m_sat = (m_sat < SAT_MAX) ? m_sat + 1 : SAT_MAX;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic vr);
        bit a, f;
        cycle(1'b0, '0, 1'b0, vr, 1'b0, a, f);
    endtask

    task automatic drain();
        for (int t = 0; t < 4 && m_hold; t++) idle(1'b1);
    endtask

    // Offers one element (v_ready held at vr) until the model sees it accepted.
    task automatic send(input logic [W-1:0] d, input logic l, input logic vr);
        bit a, f;
        a = 0;
        for (int t = 0; t < 8 && !a; t++) cycle(1'b1, d, l, vr, 1'b0, a, f);
        check("send_accepted", VW'(a), VW'(1));
    endtask

    initial begin : main
        bit a, f;
        int sent, fires, cyc;
        bit started;
        s_valid = 0; s_data = '0; s_last = 0; v_ready = 0; sat_clr = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        check("rst_v_data", v_data, '0);
        check("rst_v_mask", VW'(v_mask), '0);
        check("rst_v_last", VW'(v_last), '0);

        // Full row of 1.0..8.0 ending with s_last on lane 7.
        for (int k = 1; k <= 8; k++) send(64'(k) << 16, k == 8, 1'b1);
        drain();

        // Short row: partial vector with unused lanes zero.
        for (int k = 1; k <= 3; k++) send(64'(k) << 16, k == 3, 1'b1);
        check("partial_mask", VW'(v_mask), VW'(8'h07));
        check("partial_upper", v_data >> (3 * W), '0);
        drain();

        // Clamp boundaries: only the two out-of-range values count.
        send(64'h9_0000, 1'b0, 1'b1);
        send(-64'sd786432, 1'b0, 1'b1);
        send(64'h8_0000, 1'b0, 1'b1);
        send(-64'sh8_0000, 1'b1, 1'b1);
        check("sat_two", VW'(sat_count), VW'(2));
        drain();

        // Back-pressure: vector held 5 cycles, then a second vector.
        for (int k = 0; k < 8; k++) send(rand_elem(), 1'b0, 1'b0);
        repeat (5) idle(1'b0);
        idle(1'b1);
        for (int k = 0; k < 8; k++) send(rand_elem(), k == 7, 1'b1);
        drain();

        // 16 back-to-back elements: two vectors, 18 cycles first accept to second handover.
        sent = 0; fires = 0; cyc = 0; started = 0;
        for (int t = 0; t < 40 && fires < 2; t++) begin
            cycle(sent < 16, rand_elem(), sent == 15, 1'b1, 1'b0, a, f);
            if (a) begin
                started = 1;
                sent++;
            end
            if (started) cyc++;
            if (f) fires++;
        end
        check("b2b_vectors", VW'(fires), VW'(2));
        check("b2b_cycles", VW'(cyc), VW'(18));

        // Random traffic.
        for (int t = 0; t < 400; t++)
            cycle($urandom_range(0, 3) != 0, rand_elem(), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0, a, f);
        drain();

        // Counter saturation, then clear winning over a concurrent clamp.
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, a, f);
        sent = 0;
        for (int t = 0; t < 80000 && sent < SAT_MAX + 2; t++) begin
            cycle(1'b1, 64'h7FFF_0000_0000_0000, 1'b0, 1'b1, 1'b0, a, f);
            if (a) sent++;
        end
        check("sat_sent", VW'(sent), VW'(SAT_MAX + 2));
        check("sat_full", VW'(sat_count), VW'(16'hFFFF));
        drain();
        cycle(1'b1, 64'h7FFF_0000_0000_0000, 1'b0, 1'b1, 1'b1, a, f);
        check("clr_accepted", VW'(a), VW'(1));
        check("sat_clr_prio", VW'(sat_count), '0);
        drain();

        // Reset in the middle of a vector discards it.
        for (int k = 0; k < 8 && cur.size() != 0; k++) send(rand_elem(), 1'b1, 1'b1);
        drain();
        for (int k = 0; k < 4; k++) send(64'(k + 1) << 16, 1'b0, 1'b1);
        rst_n = 0;
        #1;
        check("midrst_v_valid", VW'(v_valid), '0);
        check("midrst_v_mask", VW'(v_mask), '0);
        check("midrst_v_data", v_data, '0);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        repeat (4) idle(1'b1);
        for (int k = 1; k <= 2; k++) send(64'(k) << 16, k == 2, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
